// File: rtl/z_core_alu_iter.sv
// ---------------------------------------------------------------------------
// z_core_alu_iter
//   Multi-cycle integer execution unit for the Z-Core. Shifts run iteratively,
//   SHIFT_STEP bits per clock. Every other operation completes in one clock.
//   Valid/ready handshakes on both sides let the control FSM stall issue.
//
// Ports
//   clk, rst       clock (rising edge); asynchronous active-high reset
//   in_valid       request valid           in_ready    accepting (IDLE only)
//   alu_inst_type  4-bit op code           alu_in1/2   operands
//   out_valid      result valid (DONE)     out_ready   consumer accepts result
//   alu_out        result                  alu_branch  branch taken (ops 10-15)
//   busy           SHIFT or DONE
// ---------------------------------------------------------------------------
module z_core_alu_iter #(
    parameter int DATA_WIDTH = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            alu_inst_type,
    input  logic [DATA_WIDTH-1:0] alu_in1,
    input  logic [DATA_WIDTH-1:0] alu_in2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] alu_out,
    output logic                  alu_branch,
    output logic                  busy
);

    localparam int SA_W = $clog2(DATA_WIDTH);
    // One extra bit so the step size (up to 8) fits even when DATA_WIDTH=8.
    localparam int RW = SA_W + 1;
    localparam logic [RW-1:0] STEP_W = RW'(SHIFT_STEP);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;
    localparam logic [3:0] OP_BEQ  = 4'd10;
    localparam logic [3:0] OP_BNE  = 4'd11;
    localparam logic [3:0] OP_BLT  = 4'd12;
    localparam logic [3:0] OP_BGE  = 4'd13;
    localparam logic [3:0] OP_BLTU = 4'd14;
    localparam logic [3:0] OP_BGEU = 4'd15;

    localparam logic [1:0] K_SLL = 2'd0;
    localparam logic [1:0] K_SRL = 2'd1;
    localparam logic [1:0] K_SRA = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            r_kind;
    logic [RW-1:0]         r_rem;
    logic [DATA_WIDTH-1:0] r_res;   // shift register, then held result
    logic                  r_branch;

    logic                  w_is_shift;
    logic [1:0]            w_kind;
    logic [RW-1:0]         w_amt;
    logic [RW-1:0]         w_first;
    logic [RW-1:0]         w_rem_after;
    logic                  w_lt_s;
    logic                  w_lt_u;
    logic                  w_eq;
    logic [DATA_WIDTH-1:0] w_res;
    logic                  w_br;
    logic [RW-1:0]         w_step;

    // Shift by a small amount (0..SHIFT_STEP). SRA replicates the current MSB,
    // which always equals the original operand's MSB.
    function automatic logic [DATA_WIDTH-1:0] f_shift(
        input logic [DATA_WIDTH-1:0] v,
        input logic [1:0]            kind,
        input logic [RW-1:0]         n
    );
        logic [DATA_WIDTH-1:0] res;
        case (kind)
            K_SLL:   res = v << n;
            K_SRL:   res = v >> n;
            default: res = $signed(v) >>> n;
        endcase
        f_shift = res;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] f_bit(input logic b);
        f_bit = {{(DATA_WIDTH-1){1'b0}}, b};
    endfunction

    always_comb begin
        w_is_shift = (alu_inst_type == OP_SLL) || (alu_inst_type == OP_SRL) ||
                     (alu_inst_type == OP_SRA);
        case (alu_inst_type)
            OP_SRL:  w_kind = K_SRL;
            OP_SRA:  w_kind = K_SRA;
            default: w_kind = K_SLL;
        endcase
        // Upper bits of alu_in2 are deliberately ignored for the amount.
        w_amt       = {1'b0, alu_in2[SA_W-1:0]};
        // The first step is taken on the capture edge itself, so a shift of
        // N bits reaches DONE after ceil(N/SHIFT_STEP) edges in total.
        w_first     = (w_amt > STEP_W) ? STEP_W : w_amt;
        w_rem_after = w_amt - w_first;

        w_lt_s = $signed(alu_in1) < $signed(alu_in2);
        w_lt_u = alu_in1 < alu_in2;
        w_eq   = alu_in1 == alu_in2;

        w_res = '0;
        w_br  = 1'b0;
        case (alu_inst_type)
            OP_ADD:  w_res = alu_in1 + alu_in2;
            OP_SUB:  w_res = alu_in1 - alu_in2;
            OP_SLT:  w_res = f_bit(w_lt_s);
            OP_SLTU: w_res = f_bit(w_lt_u);
            OP_XOR:  w_res = alu_in1 ^ alu_in2;
            OP_OR:   w_res = alu_in1 | alu_in2;
            OP_AND:  w_res = alu_in1 & alu_in2;
            OP_BEQ:  w_br  = w_eq;
            OP_BNE:  w_br  = !w_eq;
            OP_BLT:  w_br  = w_lt_s;
            OP_BGE:  w_br  = !w_lt_s;
            OP_BLTU: w_br  = w_lt_u;
            OP_BGEU: w_br  = !w_lt_u;
            default: w_res = f_shift(alu_in1, w_kind, w_first);
        endcase
        if (alu_inst_type >= OP_BEQ) begin
            w_res = f_bit(w_br);
        end

        w_step = (r_rem > STEP_W) ? STEP_W : r_rem;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_kind   <= K_SLL;
            r_rem    <= '0;
            r_res    <= '0;
            r_branch <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_res    <= w_res;
                        r_branch <= w_br;
                        r_kind   <= w_kind;
                        r_rem    <= w_rem_after;
                        if (w_is_shift && (w_rem_after != '0)) begin
                            r_state <= S_SHIFT;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    r_res <= f_shift(r_res, r_kind, w_step);
                    r_rem <= r_rem - w_step;
                    if (r_rem == w_step) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = (r_state == S_DONE);
    assign busy       = (r_state != S_IDLE);
    assign alu_out    = r_res;
    assign alu_branch = r_branch;

endmodule

// File: tb/tb_z_core_alu_iter.sv
// ---------------------------------------------------------------------------
// tb_z_core_alu_iter
//   Directed bench for z_core_alu_iter. Two instances share clock, reset and
//   operands: u_dut1 (SHIFT_STEP=1) carries most vectors, u_dut4
//   (SHIFT_STEP=4) checks the multi-bit step latency.
// ---------------------------------------------------------------------------
module tb_z_core_alu_iter;

    logic        clk;
    logic        rst;
    logic [3:0]  alu_inst_type;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;

    logic        in_valid1, in_ready1, out_valid1, out_ready1, alu_branch1, busy1;
    logic [31:0] alu_out1;
    logic        in_valid4, in_ready4, out_valid4, out_ready4, alu_branch4, busy4;
    logic [31:0] alu_out4;

    int vectors;
    int miscompares;

    z_core_alu_iter #(.DATA_WIDTH(32), .SHIFT_STEP(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .alu_inst_type(alu_inst_type), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .alu_out(alu_out1), .alu_branch(alu_branch1), .busy(busy1)
    );

    z_core_alu_iter #(.DATA_WIDTH(32), .SHIFT_STEP(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .alu_inst_type(alu_inst_type), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .alu_out(alu_out4), .alu_branch(alu_branch4), .busy(busy4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op on u_dut1 with out_ready high; measure latency, check
    // result, then confirm the unit is back in IDLE one cycle later.
    // Called at 1 time unit after a rising edge with the unit idle.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input logic [31:0] exp_out,
                          input logic exp_br);
        int lat;
        check({tag, ".in_ready_pre"}, 32'(in_ready1), 32'd1);
        alu_inst_type = op;
        alu_in1       = a;
        alu_in2       = b;
        in_valid1     = 1'b1;
        out_ready1    = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        // Scramble inputs: the operation in flight must not notice.
        alu_in1       = ~a;
        alu_in2       = ~b;
        alu_inst_type = ~op;
        lat = 1;
        while (!out_valid1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".alu_out"}, alu_out1, exp_out);
        check({tag, ".alu_branch"}, 32'(alu_branch1), 32'(exp_br));
        @(posedge clk); #1;
        check({tag, ".in_ready_post"}, 32'(in_ready1), 32'd1);
        check({tag, ".out_valid_post"}, 32'(out_valid1), 32'd0);
        $display("op %s: latency %0d alu_out %h alu_branch %0b", tag, lat, alu_out1, alu_branch1);
    endtask

    initial begin
        int lat;
        vectors     = 0;
        miscompares = 0;
        clk         = 1'b0;
        rst         = 1'b1;
        in_valid1   = 1'b0;
        in_valid4   = 1'b0;
        out_ready1  = 1'b0;
        out_ready4  = 1'b0;
        alu_inst_type = 4'd0;
        alu_in1     = 32'd0;
        alu_in2     = 32'd0;

        // Reset state
        #2;
        check("rst.in_ready", 32'(in_ready1), 32'd1);
        check("rst.out_valid", 32'(out_valid1), 32'd0);
        check("rst.alu_out", alu_out1, 32'd0);
        check("rst.alu_branch", 32'(alu_branch1), 32'd0);
        check("rst.busy", 32'(busy1), 32'd0);
        check("rst.in_ready4", 32'(in_ready4), 32'd1);
        $display("reset: in_ready %0b out_valid %0b busy %0b", in_ready1, out_valid1, busy1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Single-cycle ops and iterative shifts (SHIFT_STEP=1)
        run_op("ADD",  4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 1,  32'h8000_0000, 1'b0);
        run_op("SUB",  4'd1,  32'h0000_0003, 32'h0000_0005, 1,  32'hFFFF_FFFE, 1'b0);
        run_op("SRA31",4'd7,  32'h8000_0000, 32'd31,        31, 32'hFFFF_FFFF, 1'b0);
        run_op("SRA4", 4'd7,  32'h8000_0000, 32'd4,         4,  32'hF800_0000, 1'b0);
        run_op("SLL0", 4'd2,  32'h0000_0001, 32'h0000_0020, 1,  32'h0000_0001, 1'b0);
        run_op("SRL",  4'd6,  32'h0000_00F0, 32'd4,         4,  32'h0000_000F, 1'b0);
        run_op("SLT",  4'd3,  32'hFFFF_FFFF, 32'h0000_0001, 1,  32'h0000_0001, 1'b0);
        run_op("SLTU", 4'd4,  32'hFFFF_FFFF, 32'h0000_0001, 1,  32'h0000_0000, 1'b0);
        run_op("OR",   4'd8,  32'hF0F0_0000, 32'h0000_0F0F, 1,  32'hF0F0_0F0F, 1'b0);
        run_op("AND",  4'd9,  32'hFF00_FF00, 32'h0FF0_0FF0, 1,  32'h0F00_0F00, 1'b0);
        run_op("BLT",  4'd12, 32'hFFFF_FFFF, 32'h0000_0001, 1,  32'h0000_0001, 1'b1);
        run_op("BLTU", 4'd14, 32'hFFFF_FFFF, 32'h0000_0001, 1,  32'h0000_0000, 1'b0);
        run_op("BGEU", 4'd15, 32'hFFFF_FFFF, 32'h0000_0001, 1,  32'h0000_0001, 1'b1);
        run_op("BGE",  4'd13, 32'hFFFF_FFFF, 32'h0000_0001, 1,  32'h0000_0000, 1'b0);
        run_op("BNE",  4'd11, 32'hFFFF_FFFF, 32'h0000_0001, 1,  32'h0000_0001, 1'b1);
        run_op("BEQ",  4'd10, 32'h0000_0005, 32'h0000_0005, 1,  32'h0000_0001, 1'b1);

        // SRA by 31 with SHIFT_STEP=4: ceil(31/4) = 8 cycles
        alu_inst_type = 4'd7;
        alu_in1       = 32'h8000_0000;
        alu_in2       = 32'd31;
        in_valid4     = 1'b1;
        out_ready4    = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        alu_in1   = 32'd0;
        lat = 1;
        while (!out_valid4 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("SRA31_STEP4.latency", 32'(lat), 32'd8);
        check("SRA31_STEP4.alu_out", alu_out4, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        check("SRA31_STEP4.in_ready_post", 32'(in_ready4), 32'd1);
        $display("op SRA31_STEP4: latency %0d alu_out %h", lat, alu_out4);

        // Backpressure: XOR held in DONE for 5 cycles, stray requests ignored
        alu_inst_type = 4'd5;
        alu_in1       = 32'hA5A5_A5A5;
        alu_in2       = 32'hFFFF_0000;
        in_valid1     = 1'b1;
        out_ready1    = 1'b0;
        @(posedge clk); #1;
        alu_inst_type = 4'd0;
        alu_in1       = 32'h1111_1111;
        alu_in2       = 32'h2222_2222;
        for (int i = 0; i < 5; i++) begin
            in_valid1 = i[0];
            check("STALL.out_valid", 32'(out_valid1), 32'd1);
            check("STALL.alu_out", alu_out1, 32'h5A5A_A5A5);
            check("STALL.busy", 32'(busy1), 32'd1);
            check("STALL.in_ready", 32'(in_ready1), 32'd0);
            $display("stall cycle %0d: out_valid %0b alu_out %h busy %0b", i, out_valid1, alu_out1, busy1);
            @(posedge clk); #1;
        end
        check("STALL.hold_end", alu_out1, 32'h5A5A_A5A5);
        in_valid1  = 1'b0;
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        check("STALL.release_in_ready", 32'(in_ready1), 32'd1);
        check("STALL.release_out_valid", 32'(out_valid1), 32'd0);
        check("STALL.release_alu_out", alu_out1, 32'h5A5A_A5A5);
        $display("release: in_ready %0b out_valid %0b", in_ready1, out_valid1);

        // Reset in the middle of a 20-bit SLL
        alu_inst_type = 4'd2;
        alu_in1       = 32'h0000_0001;
        alu_in2       = 32'd20;
        in_valid1     = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("MIDRST.busy_before", 32'(busy1), 32'd1);
        rst = 1'b1;
        #1;
        check("MIDRST.out_valid", 32'(out_valid1), 32'd0);
        check("MIDRST.in_ready", 32'(in_ready1), 32'd1);
        check("MIDRST.alu_out", alu_out1, 32'd0);
        check("MIDRST.busy", 32'(busy1), 32'd0);
        $display("mid-shift reset: out_valid %0b in_ready %0b alu_out %h", out_valid1, in_ready1, alu_out1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_op("ADD_AFTER_RST", 4'd0, 32'd2, 32'd3, 1, 32'd5, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
